// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl
//   EX-stage front end for an iterative divider. Decodes DIV/DIVU/MTHI/MTLO,
//   holds the operands and the run enable steady at the divider for the whole
//   divide, and collects the quotient/remainder into the architectural LO/HI
//   registers. It stalls EX while a divide is in flight and applies pipeline
//   flushes so that a divider past its cancel window is always drained cleanly.
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   ex_valid, ex_op       EX instruction valid / opcode (1 DIV, 2 DIVU, 3 MTHI, 4 MTLO)
//   ex_rs_val, ex_rt_val  rs (dividend / MT source) and rt (divisor) operands
//   ex_hold, flush        external EX hold; kill of the instruction in EX
//   div_en, div_signed    divider run enable and signed-mode select
//   div_x, div_y          registered dividend / divisor
//   div_cancel            one-cycle abort pulse (only inside the cancel window)
//   div_s, div_r          quotient / remainder from the divider
//   div_complete          one-cycle pulse: div_s/div_r valid
//   hi, lo                architectural HI / LO registers
//   ex_stall              combinational EX stall
//   busy                  controller not idle
module hilo_div_ctrl #(
  parameter int DW         = 32,
  parameter int CANCEL_WIN = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ex_valid,
  input  logic [2:0]    ex_op,
  input  logic [DW-1:0] ex_rs_val,
  input  logic [DW-1:0] ex_rt_val,
  input  logic          ex_hold,
  input  logic          flush,
  output logic          div_en,
  output logic          div_signed,
  output logic [DW-1:0] div_x,
  output logic [DW-1:0] div_y,
  output logic          div_cancel,
  input  logic [DW-1:0] div_s,
  input  logic [DW-1:0] div_r,
  input  logic          div_complete,
  output logic [DW-1:0] hi,
  output logic [DW-1:0] lo,
  output logic          ex_stall,
  output logic          busy
);

  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_DIVU = 3'd2;
  localparam logic [2:0] OP_MTHI = 3'd3;
  localparam logic [2:0] OP_MTLO = 3'd4;

  // cnt saturates here; a flush at or beyond it can no longer cancel.
  localparam logic [1:0] CNT_SAT = 2'(CANCEL_WIN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [DW-1:0] hi_q, hi_d;
  logic [DW-1:0] lo_q, lo_d;
  logic [DW-1:0] div_x_q, div_x_d;
  logic [DW-1:0] div_y_q, div_y_d;
  logic          div_signed_q, div_signed_d;
  logic          div_en_q, div_en_d;
  logic          div_cancel_q, div_cancel_d;

  logic op_is_div;
  logic op_is_mt;

  assign op_is_div = (ex_op == OP_DIV) || (ex_op == OP_DIVU);
  assign op_is_mt  = (ex_op == OP_MTHI) || (ex_op == OP_MTLO);

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    div_x_d      = div_x_q;
    div_y_d      = div_y_q;
    div_signed_d = div_signed_q;
    div_cancel_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ex_valid && op_is_div && !flush) begin
          // Operands are captured only here and never re-sampled mid-divide.
          state_d      = BUSY;
          cnt_d        = 2'd0;
          div_x_d      = ex_rs_val;
          div_y_d      = ex_rt_val;
          div_signed_d = (ex_op == OP_DIV);
        end else if (ex_valid && op_is_mt && !flush && !ex_hold) begin
          if (ex_op == OP_MTHI) begin
            hi_d = ex_rs_val;
          end else begin
            lo_d = ex_rs_val;
          end
        end
      end
      BUSY: begin
        if (cnt_q < CNT_SAT) begin
          cnt_d = cnt_q + 2'd1;
        end
        // A result arriving together with a flush belongs to a killed
        // instruction: drop it. The divider has finished, so no cancel.
        if (flush && div_complete) begin
          state_d = IDLE;
        end else if (flush && (cnt_q < CNT_SAT)) begin
          state_d      = IDLE;
          div_cancel_d = 1'b1;
        end else if (flush) begin
          // Too late to cancel: keep the divider running until it reports.
          state_d = DRAIN;
        end else if (div_complete) begin
          lo_d    = div_s;
          hi_d    = div_r;
          state_d = DONE;
        end
      end
      DRAIN: begin
        if (div_complete) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        // Holding here while EX is held stops the same DIV from re-issuing.
        if (!ex_hold || flush) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Enable is registered so it rises the cycle after issue and drops for at
    // least one cycle after every completion or cancel.
    div_en_d = (state_d == BUSY) || (state_d == DRAIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      hi_q         <= '0;
      lo_q         <= '0;
      div_x_q      <= '0;
      div_y_q      <= '0;
      div_signed_q <= 1'b0;
      div_en_q     <= 1'b0;
      div_cancel_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      div_x_q      <= div_x_d;
      div_y_q      <= div_y_d;
      div_signed_q <= div_signed_d;
      div_en_q     <= div_en_d;
      div_cancel_q <= div_cancel_d;
    end
  end

  // Stall is forced low during reset so EX is not frozen by stale state.
  always_comb begin
    ex_stall = 1'b0;
    if (!reset && ex_valid) begin
      ex_stall = (op_is_div && ((state_q == IDLE) || (state_q == BUSY)))
              || (op_is_mt  && ((state_q == BUSY) || (state_q == DRAIN)))
              || (state_q == DRAIN);
    end
  end

  assign busy       = (state_q != IDLE);
  assign div_en     = div_en_q;
  assign div_signed = div_signed_q;
  assign div_x      = div_x_q;
  assign div_y      = div_y_q;
  assign div_cancel = div_cancel_q;
  assign hi         = hi_q;
  assign lo         = lo_q;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Testbench for hilo_div_ctrl: a divider stub answers each enabled divide
// after a programmable latency; expected HI/LO for each issued divide are
// queued at issue and compared when the divide retires.
module tb_hilo_div_ctrl;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_DIVU = 3'd2;
  localparam logic [2:0] OP_MTHI = 3'd3;
  localparam logic [2:0] OP_MTLO = 3'd4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [2:0]  ex_op;
  logic [31:0] ex_rs_val;
  logic [31:0] ex_rt_val;
  logic        ex_hold;
  logic        flush;
  logic        div_en;
  logic        div_signed;
  logic [31:0] div_x;
  logic [31:0] div_y;
  logic        div_cancel;
  logic [31:0] div_s = '0;
  logic [31:0] div_r = '0;
  logic        div_complete = 1'b0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        ex_stall;
  logic        busy;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          stub_lat = 34;
  int          stub_cnt = 0;
  bit          stub_done = 1'b0;

  always #5 clk = ~clk;

  hilo_div_ctrl #(.DW(32), .CANCEL_WIN(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .ex_valid     (ex_valid),
    .ex_op        (ex_op),
    .ex_rs_val    (ex_rs_val),
    .ex_rt_val    (ex_rt_val),
    .ex_hold      (ex_hold),
    .flush        (flush),
    .div_en       (div_en),
    .div_signed   (div_signed),
    .div_x        (div_x),
    .div_y        (div_y),
    .div_cancel   (div_cancel),
    .div_s        (div_s),
    .div_r        (div_r),
    .div_complete (div_complete),
    .hi           (hi),
    .lo           (lo),
    .ex_stall     (ex_stall),
    .busy         (busy)
  );

  // Divider stub: counts enabled cycles, pulses complete once at stub_lat.
  always @(negedge clk) begin
    if (reset || !div_en) begin
      stub_cnt     = 0;
      stub_done    = 1'b0;
      div_complete = 1'b0;
    end else if (stub_done) begin
      div_complete = 1'b0;
    end else begin
      stub_cnt++;
      if (stub_cnt >= stub_lat) begin
        if (div_signed) begin
          div_s = $signed(div_x) / $signed(div_y);
          div_r = $signed(div_x) % $signed(div_y);
        end else begin
          div_s = div_x / div_y;
          div_r = div_x % div_y;
        end
        div_complete = 1'b1;
        stub_done    = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ex();
    ex_valid = 1'b0;
    ex_op    = OP_NONE;
    flush    = 1'b0;
    ex_hold  = 1'b0;
  endtask

  // Waits for the stub's complete pulse; returns at negedge+1 with it high.
  task automatic wait_complete(output bit ok, output bit stall_dropped);
    ok = 1'b0;
    stall_dropped = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (!ex_stall) stall_dropped = 1'b1;
      if (div_complete) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Presents a divide in EX, queues its expected result, checks the latch.
  task automatic issue_div(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                           input logic [31:0] e_lo, input logic [31:0] e_hi);
    exp_t e;
    ex_valid = 1'b1; ex_op = op; ex_rs_val = rs; ex_rt_val = rt;
    #1;
    n_checks++; if (ex_stall !== 1'b1) $display("FAIL issue_stall: got %b want 1", ex_stall); else n_pass++;
    e.lo = e_lo; e.hi = e_hi;
    sb.push_back(e);
    tick();
    n_checks++; if (div_x !== rs) $display("FAIL div_x: got %h want %h", div_x, rs); else n_pass++;
    n_checks++; if (div_y !== rt) $display("FAIL div_y: got %h want %h", div_y, rt); else n_pass++;
    n_checks++; if (div_signed !== (op == OP_DIV)) $display("FAIL div_signed: got %b want %b", div_signed, op == OP_DIV); else n_pass++;
    n_checks++; if ({busy, div_en} !== 2'b11) $display("FAIL busy_en: got %b want 11", {busy, div_en}); else n_pass++;
  endtask

  // Waits for the result, then checks the retire cycle against the scoreboard.
  task automatic finish_div(input string name);
    bit   ok, dropped;
    exp_t e;
    wait_complete(ok, dropped);
    n_checks++; if (!ok) $display("FAIL %s_timeout: got no div_complete want pulse", name); else n_pass++;
    n_checks++; if (dropped) $display("FAIL %s_stall_busy: got 0 want 1", name); else n_pass++;
    tick();
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL %s_scoreboard: got empty queue want entry", name);
    end else begin
      e = sb.pop_front();
      m_lo = e.lo; m_hi = e.hi;
      n_checks++; if (lo !== e.lo) $display("FAIL %s_lo: got %h want %h", name, lo, e.lo); else n_pass++;
      n_checks++; if (hi !== e.hi) $display("FAIL %s_hi: got %h want %h", name, hi, e.hi); else n_pass++;
    end
    n_checks++; if ({busy, div_en, ex_stall} !== 3'b100) $display("FAIL %s_done: busy/en/stall got %b want 100", name, {busy, div_en, ex_stall}); else n_pass++;
    $display("div %s: lo=%h hi=%h", name, lo, hi);
  endtask

  task automatic test_reset();
    reset = 1'b1; idle_ex();
    ex_rs_val = '0; ex_rt_val = '0;
    tick(); tick();
    ex_valid = 1'b1; ex_op = OP_DIV;
    #1;
    n_checks++; if ({div_en, div_signed, div_cancel, busy, ex_stall} !== 5'b0) $display("FAIL reset_ctrl: got %b want 00000", {div_en, div_signed, div_cancel, busy, ex_stall}); else n_pass++;
    n_checks++; if ({hi, lo, div_x, div_y} !== 128'b0) $display("FAIL reset_data: got %h want 0", {hi, lo, div_x, div_y}); else n_pass++;
    ex_valid = 1'b0; ex_op = OP_NONE;
    tick();
    reset = 1'b0;
    tick();
    $display("reset released");
  endtask

  task automatic test_div_signed();
    issue_div(OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    finish_div("div_signed");
    tick();
    idle_ex();
    n_checks++; if (busy !== 1'b0) $display("FAIL div_signed_idle: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_divu_hold();
    issue_div(OP_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF);
    ex_hold = 1'b1;
    finish_div("divu");
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if ({busy, div_en, lo} !== {2'b10, m_lo}) $display("FAIL divu_hold%0d: busy/en/lo got %b %h want 10 %h", i, {busy, div_en}, lo, m_lo); else n_pass++;
    end
    ex_hold = 1'b0;
    tick();
    idle_ex();
    n_checks++; if (busy !== 1'b0) $display("FAIL divu_release: got %b want 0", busy); else n_pass++;
    $display("divu held in DONE then released");
  endtask

  task automatic test_cancel();
    issue_div(OP_DIVU, 32'd100, 32'd3, 32'd0, 32'd0);
    void'(sb.pop_back());   // this divide is cancelled and never retires
    tick();                 // cnt now 1
    flush = 1'b1;
    tick();
    n_checks++; if ({div_cancel, div_en, busy} !== 3'b100) $display("FAIL cancel_pulse: cancel/en/busy got %b want 100", {div_cancel, div_en, busy}); else n_pass++;
    n_checks++; if ({hi, lo} !== {m_hi, m_lo}) $display("FAIL cancel_hilo: got %h want %h", {hi, lo}, {m_hi, m_lo}); else n_pass++;
    idle_ex();
    tick();
    n_checks++; if (div_cancel !== 1'b0) $display("FAIL cancel_once: got %b want 0", div_cancel); else n_pass++;
    $display("cancel at cnt=1");
  endtask

  task automatic test_drain_mthi();
    bit ok, dropped;
    issue_div(OP_DIV, 32'd50, 32'd7, 32'd0, 32'd0);
    void'(sb.pop_back());   // flushed after the cancel window: drained
    tick(); tick(); tick(); // cnt now 3
    flush = 1'b1;
    tick();
    n_checks++; if ({busy, div_en, div_cancel} !== 3'b110) $display("FAIL drain_enter: busy/en/cancel got %b want 110", {busy, div_en, div_cancel}); else n_pass++;
    flush = 1'b0; ex_valid = 1'b1; ex_op = OP_MTHI; ex_rs_val = 32'h1234;
    #1;
    n_checks++; if (ex_stall !== 1'b1) $display("FAIL drain_mthi_stall: got %b want 1", ex_stall); else n_pass++;
    wait_complete(ok, dropped);
    n_checks++; if (!ok || dropped) $display("FAIL drain_wait: ok/stall_dropped got %b%b want 10", ok, dropped); else n_pass++;
    tick();
    n_checks++; if ({busy, div_en} !== 2'b00) $display("FAIL drain_exit: busy/en got %b want 00", {busy, div_en}); else n_pass++;
    n_checks++; if ({hi, lo} !== {m_hi, m_lo}) $display("FAIL drain_hilo: got %h want %h", {hi, lo}, {m_hi, m_lo}); else n_pass++;
    tick();
    m_hi = 32'h1234;
    n_checks++; if (hi !== m_hi) $display("FAIL mthi_write: got %h want %h", hi, m_hi); else n_pass++;
    idle_ex();
    $display("drain then mthi hi=%h", hi);
  endtask

  task automatic test_mtlo_flush();
    ex_valid = 1'b1; ex_op = OP_MTLO; ex_rs_val = 32'hABCD; flush = 1'b1;
    tick();
    n_checks++; if (lo !== m_lo) $display("FAIL mtlo_flushed: got %h want %h", lo, m_lo); else n_pass++;
    flush = 1'b0; ex_hold = 1'b1;
    tick();
    n_checks++; if (lo !== m_lo) $display("FAIL mtlo_held: got %h want %h", lo, m_lo); else n_pass++;
    ex_hold = 1'b0;
    #1;
    n_checks++; if (ex_stall !== 1'b0) $display("FAIL mtlo_stall: got %b want 0", ex_stall); else n_pass++;
    tick();
    m_lo = 32'hABCD;
    n_checks++; if (lo !== m_lo) $display("FAIL mtlo_write: got %h want %h", lo, m_lo); else n_pass++;
    idle_ex();
    $display("mtlo lo=%h", lo);
  endtask

  task automatic test_flush_complete();
    bit ok, dropped;
    stub_lat = 5;
    issue_div(OP_DIVU, 32'd99, 32'd4, 32'd0, 32'd0);
    void'(sb.pop_back());   // result arrives with a flush: discarded
    wait_complete(ok, dropped);
    n_checks++; if (!ok) $display("FAIL fc_timeout: got no div_complete want pulse"); else n_pass++;
    flush = 1'b1;
    tick();
    n_checks++; if ({busy, div_cancel} !== 2'b00) $display("FAIL fc_state: busy/cancel got %b want 00", {busy, div_cancel}); else n_pass++;
    n_checks++; if ({hi, lo} !== {m_hi, m_lo}) $display("FAIL fc_hilo: got %h want %h", {hi, lo}, {m_hi, m_lo}); else n_pass++;
    idle_ex();
    tick();
    stub_lat = 34;
    $display("flush with complete discarded");
  endtask

  task automatic test_reset_mid_busy();
    issue_div(OP_DIV, 32'd1000, 32'd9, 32'd0, 32'd0);
    void'(sb.pop_back());
    tick();
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if ({div_en, busy, ex_stall} !== 3'b000) $display("FAIL rst_async_ctrl: en/busy/stall got %b want 000", {div_en, busy, ex_stall}); else n_pass++;
    n_checks++; if ({div_x, hi, lo} !== 96'b0) $display("FAIL rst_async_data: got %h want 0", {div_x, hi, lo}); else n_pass++;
    #2;
    reset = 1'b0;
    idle_ex();
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_after: got %b want 0", busy); else n_pass++;
    $display("async reset mid-divide");
  endtask

  initial begin
    test_reset();
    test_div_signed();
    test_divu_hold();
    test_cancel();
    test_drain_mthi();
    test_mtlo_flush();
    test_flush_complete();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
